// File: rtl/byte_unit_pipe.sv
// byte_unit_pipe: byte-class execution unit (cntb, avgb, absdb, sumbh) with a
// valid-tagged LATENCY-deep result pipeline, selective flush and a forwarding
// packet {result, unit id, wr_en, rt}.
// Optional: define BYTE_UNIT_SADB_EN to enable the sadbh opcode.
module byte_unit_pipe #(
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned FLUSH_DEPTH = 1,
   parameter int unsigned UNIT_ID     = 4,
   parameter int unsigned RT_W        = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [10:0]               opcode,
   input  logic [DATA_W-1:0]         data_ra,
   input  logic [DATA_W-1:0]         data_rb,
   input  logic [RT_W-1:0]           addr_rt,
   output logic                      out_valid,
   output logic [DATA_W+4+RT_W-1:0]  out_data,
   output logic [LATENCY*RT_W-1:0]   stage_rt,
   output logic [LATENCY-1:0]        stage_wr,
   output logic                      busy
);

   localparam int unsigned PKT_W = DATA_W + 4 + RT_W;
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned NW    = DATA_W / 32;

   localparam logic [10:0] OP_CNTB  = 11'b01010110100;
   localparam logic [10:0] OP_AVGB  = 11'b00011010011;
   localparam logic [10:0] OP_ABSDB = 11'b00001010011;
   localparam logic [10:0] OP_SUMBH = 11'b01001010011;
`ifdef BYTE_UNIT_SADB_EN
   localparam logic [10:0] OP_SADBH = 11'b00101010011;
`endif

   logic [DATA_W-1:0]              res_c;
   logic                           wr_c;
   logic [PKT_W-1:0]               pkt_c;
   logic [LATENCY-1:0]             valid_d, valid_q;
   logic [LATENCY-1:0][PKT_W-1:0]  pkt_d, pkt_q;
   logic                           busy_q;

   function automatic logic [7:0] popcnt8(input logic [7:0] x);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + 8'(x[i]);
      return n;
   endfunction

   // Rounding average at 9 bits so 0xFF+0xFF+1 cannot wrap.
   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = 9'(a) + 9'(b) + 9'd1;
      return s[8:1];
   endfunction

   function automatic logic [7:0] absd8(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [15:0] sum4(input logic [31:0] x);
      return 16'(x[31:24]) + 16'(x[23:16]) + 16'(x[15:8]) + 16'(x[7:0]);
   endfunction

`ifdef BYTE_UNIT_SADB_EN
   function automatic logic [15:0] sad4(input logic [31:0] a, input logic [31:0] b);
      logic [15:0] s;
      s = '0;
      for (int i = 0; i < 4; i++) s = s + 16'(absd8(a[8*i +: 8], b[8*i +: 8]));
      return s;
   endfunction
`endif

   // Stage-1 datapath: decode opcode and compute the lane result.
   always_comb begin
      res_c = '0;
      wr_c  = 1'b0;
      case (opcode)
         OP_CNTB: begin
            wr_c = 1'b1;
            for (int b = 0; b < NB; b++) res_c[8*b +: 8] = popcnt8(data_ra[8*b +: 8]);
         end
         OP_AVGB: begin
            wr_c = 1'b1;
            for (int b = 0; b < NB; b++) res_c[8*b +: 8] = avg8(data_ra[8*b +: 8], data_rb[8*b +: 8]);
         end
         OP_ABSDB: begin
            wr_c = 1'b1;
            for (int b = 0; b < NB; b++) res_c[8*b +: 8] = absd8(data_ra[8*b +: 8], data_rb[8*b +: 8]);
         end
         OP_SUMBH: begin
            wr_c = 1'b1;
            for (int w = 0; w < NW; w++)
               res_c[32*w +: 32] = {sum4(data_rb[32*w +: 32]), sum4(data_ra[32*w +: 32])};
         end
`ifdef BYTE_UNIT_SADB_EN
         OP_SADBH: begin
            wr_c = 1'b1;
            for (int w = 0; w < NW; w++)
               res_c[32*w +: 32] = {16'h0000, sad4(data_ra[32*w +: 32], data_rb[32*w +: 32])};
         end
`endif
         default: ;
      endcase
      pkt_c = (in_valid && wr_c) ? {res_c, 3'(UNIT_ID), 1'b1, addr_rt} : '0;
   end

   // Pipeline next state: shift, with the FLUSH_DEPTH youngest in-flight stages squashed.
   always_comb begin
      valid_d    = '0;
      pkt_d      = '0;
      valid_d[0] = in_valid;
      pkt_d[0]   = pkt_c;
      for (int unsigned k = 1; k < LATENCY; k++) begin
         if (flush && (k <= FLUSH_DEPTH)) begin
            valid_d[k] = 1'b0;
            pkt_d[k]   = '0;
         end else begin
            valid_d[k] = valid_q[k-1];
            pkt_d[k]   = pkt_q[k-1];
         end
      end
   end

   // Stage registers; reset overrides flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         pkt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         pkt_q   <= pkt_d;
         busy_q  <= |valid_d;
      end
   end

   // Per-stage hazard view for the issue logic.
   always_comb begin
      stage_wr = '0;
      stage_rt = '0;
      for (int k = 0; k < LATENCY; k++) begin
         stage_wr[k]                = valid_q[k] & pkt_q[k][RT_W];
         stage_rt[k*RT_W +: RT_W]   = pkt_q[k][RT_W-1:0];
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = pkt_q[LATENCY-1];
   assign busy      = busy_q;

endmodule

// File: doc/byte_unit_pipe.md
Name: byte_unit_pipe

Overview:
- Parametrised byte-class execution unit for the SPU odd/even pipe.
- Computes count-ones, average, absolute-difference and sum-into-halfwords on DATA_W-bit operands in stage 1.
- Carries the result through a LATENCY-deep valid-tagged shift pipeline with selective flush.
- Emits a forwarding packet (result, unit id, write enable, target register) to the forwarding/register-file network.

Parameters:
- DATA_W, 128: operand/result width in bits; must be a multiple of 32.
- LATENCY, 4: pipeline depth in stages; legal range 2..8.
- FLUSH_DEPTH, 1: number of youngest in-flight stages squashed by flush; legal range 1..LATENCY-1.
- UNIT_ID, 4: 3-bit unit identifier inserted in every packet.
- RT_W, 7: target register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch-mispredict squash
- in_valid  in  1  instruction issued this cycle
- opcode  in  11  instruction opcode
- data_ra  in  DATA_W  operand A
- data_rb  in  DATA_W  operand B
- addr_rt  in  RT_W  destination register
- out_valid  out  1  out_data holds a live instruction
- out_data  out  DATA_W+4+RT_W  packet: {result, UNIT_ID[2:0], wr_en, rt}, with result in the MSBs
- stage_rt  out  LATENCY*RT_W  rt of each stage, stage 1 in the LSBs (for hazard checking)
- stage_wr  out  LATENCY  per-stage valid AND wr_en
- busy  out  1  OR of all stage valids

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. On reset every stage register, out_valid, out_data, stage_rt, stage_wr and busy are 0.
- Byte numbering is big-endian: byte 0 is the most significant byte of the operand.
- Stage 1 capture: at each edge, stage 1 captures {in_valid, packet computed from the current inputs}. If in_valid=0, the packet is all zero.
- Pipeline advance: stage k captures stage k-1 each edge. The output register is stage LATENCY.
- Latency: an instruction issued at edge t appears on out_data/out_valid after edge t+LATENCY-1, i.e. exactly LATENCY cycles after issue.
- Throughput: one instruction per cycle, no stalls, no backpressure.
- Opcodes (all lane arithmetic is unsigned):
  - 01010110100 cntb: each result byte = popcount of the corresponding ra byte (0..8).
  - 00011010011 avgb: each result byte = (ra+rb+1)>>1, computed at 9-bit width, so no overflow.
  - 00001010011 absdb: each result byte = |ra-rb|.
  - 01001010011 sumbh: for word lane w, upper halfword = sum of the 4 rb bytes and lower halfword = sum of the 4 ra bytes, zero-extended to 16 bits (max 1020).
- Valid opcode: wr_en=1, unit id=UNIT_ID, rt=addr_rt.
- Any other opcode: the whole packet is 0 (wr_en=0), but valid still follows in_valid, so the instruction retires silently.
- Flush: at an edge with flush=1, stages 2..FLUSH_DEPTH+1 capture all-zero instead of their predecessor.
  - This kills the FLUSH_DEPTH youngest instructions already issued.
  - Stage 1 still captures the instruction presented in the flush cycle.
  - Stages beyond FLUSH_DEPTH+1 advance normally.
- Back-to-back flushes each kill independently.
- Flush and reset together: reset wins.
- busy=0 exactly when all stage valids are 0.

Optional Feature:
- Macro: BYTE_UNIT_SADB_EN.
- When defined, opcode 00101010011 (sadbh) is valid: for each word lane, the upper halfword is 0 and the lower halfword = sum of |ra-rb| over the lane's 4 bytes (max 1020). wr_en=1.
- When undefined, that opcode is treated as an unknown opcode: packet 0, wr_en=0.
- No other behaviour changes.

Test Plan:
- Reset, then issue cntb with ra=0xFF00_0F01_8000_0003_... → result bytes 08,00,04,01,01,00,00,02 after exactly LATENCY cycles; unit field=4; rt echoed.
- avgb with ra byte=0xFF, rb byte=0xFF → 0xFF; ra=0x01, rb=0x02 → 0x02; absdb with ra=0x10, rb=0xF0 → 0xE0. Check all 16 lanes.
- sumbh with all ra bytes=0xFF and rb bytes=0x01 → each word=0x0004_03FC.
- Issue 5 consecutive instructions; assert flush on the cycle after the 3rd issue with FLUSH_DEPTH=1 → only the 3rd is missing at the output, and the 4th (issued during the flush) survives. stage_wr and busy track this.
- Unknown opcode 0x000 with in_valid=1 → out_valid=1, out_data=0. Assert reset mid-stream → all outputs 0 on the next cycle.
- With BYTE_UNIT_SADB_EN: ra word=0x0A14_1E28, rb=0x1414_1414 → lower halfword 0x0028. Without the macro: out_data=0.
